// File: rtl/shift_reg_pkg.sv
// Shared definitions for the shift-register family: FSM states, bit-order
// selectors and a constant clog2 used to size counters.
package shift_reg_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam int ORDER_LSB = 0;
    localparam int ORDER_MSB = 1;

    // Smallest r with 2**r >= value; usable in constant expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up counter with synchronous clear, enable and a terminal-count
// flag that is high while the count sits at MOD-1.
module mod_counter
    import shift_reg_pkg::*;
#(
    parameter int MOD = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CW = clog2(MOD);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign tc_o = (count_q == CW'(MOD - 1));

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = tc_o ? '0 : count_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/piso_shift_register.sv
// Parallel-in, serial-out shift register with a valid/ready load side and
// zero-gap reload on the last bit, so words stream back-to-back.
module piso_shift_register
    import shift_reg_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             s_out,
    output logic             s_valid,
    output logic             s_last,
    output logic             busy
);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_tc;
    logic             accept;
    logic             in_shift;

    assign in_shift = (state_q == ST_SHIFT);

    mod_counter #(
        .MOD (WIDTH)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .tc_o  (cnt_tc)
    );

    // Ready on the last enabled bit is what allows the zero-gap handover.
    assign load_ready = !in_shift || (shift_en && cnt_tc);
    assign accept     = load_valid && load_ready;

    // NOTE: every variable written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        if (accept) begin
            state_d = ST_SHIFT;
            shreg_d = load_data;
            cnt_clr = 1'b1;
        end else if (in_shift && shift_en) begin
            if (!cnt_tc) begin
                shreg_d = (MSB_FIRST == ORDER_MSB) ? (shreg_q << 1) : (shreg_q >> 1);
                cnt_en  = 1'b1;
            end else begin
                state_d = ST_IDLE;
                shreg_d = '0;
                cnt_clr = 1'b1;
            end
        end
    end

    // NOTE: shreg is reset as well as the state, because a discarded partial
    // word must leave no residue that could later appear on s_out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
        end
    end

    assign s_valid = in_shift;
    assign busy    = in_shift;
    assign s_last  = in_shift && cnt_tc;
    assign s_out   = in_shift &&
                     ((MSB_FIRST == ORDER_MSB) ? shreg_q[WIDTH-1] : shreg_q[0]);

endmodule

// File: tb/tb_piso_shift_register.sv
// Scoreboard bench for piso_shift_register: a 4-bit LSB-first and an 8-bit
// MSB-first instance driven by directed and random load/shift traffic.
module tb_piso_shift_register;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] lv;
    logic [1:0] se;
    logic [3:0] ld4;
    logic [7:0] ld8;
    logic [1:0] lr;
    logic [1:0] so;
    logic [1:0] sv;
    logic [1:0] sl;
    logic [1:0] bz;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected serial bits still owed by each instance, front = on s_out now.
    bit exp_q [2][$];
    // Set by the model when a presented word will be taken at the next edge.
    bit acc [2];

    always #5 clk = ~clk;

    piso_shift_register #(.WIDTH(4), .MSB_FIRST(0)) u_dut4 (
        .clk        (clk),
        .rst        (rst),
        .load_valid (lv[0]),
        .load_data  (ld4),
        .load_ready (lr[0]),
        .shift_en   (se[0]),
        .s_out      (so[0]),
        .s_valid    (sv[0]),
        .s_last     (sl[0]),
        .busy       (bz[0])
    );

    piso_shift_register #(.WIDTH(8), .MSB_FIRST(1)) u_dut8 (
        .clk        (clk),
        .rst        (rst),
        .load_valid (lv[1]),
        .load_data  (ld8),
        .load_ready (lr[1]),
        .shift_en   (se[1]),
        .s_out      (so[1]),
        .s_valid    (sv[1]),
        .s_last     (sl[1]),
        .busy       (bz[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor + reference model, evaluated mid-cycle while inputs are stable.
    always @(negedge clk) begin : monitor
        int n;
        int w;
        bit rdy;
        logic [7:0] word;
        for (int d = 0; d < 2; d++) begin
            w = (d == 0) ? 4 : 8;
            n = exp_q[d].size();
            if (!rst) begin
                check($sformatf("dut%0d reset s_out", d),      so[d], 0);
                check($sformatf("dut%0d reset s_valid", d),    sv[d], 0);
                check($sformatf("dut%0d reset s_last", d),     sl[d], 0);
                check($sformatf("dut%0d reset busy", d),       bz[d], 0);
                check($sformatf("dut%0d reset load_ready", d), lr[d], 1);
                exp_q[d].delete();
            end else begin
                // A word is busy while bits remain; the last bit hands over if enabled.
                rdy = (n == 0) || (se[d] && n == 1);
                check($sformatf("dut%0d load_ready", d), lr[d], rdy);
                check($sformatf("dut%0d s_valid", d),    sv[d], n != 0);
                check($sformatf("dut%0d busy", d),       bz[d], n != 0);
                check($sformatf("dut%0d s_last", d),     sl[d], n == 1);
                check($sformatf("dut%0d s_out", d),      so[d], (n != 0) ? exp_q[d][0] : 1'b0);
                if (se[d] && n != 0) begin
                    void'(exp_q[d].pop_front());
                end
                if (lv[d] && rdy) begin
                    word = (d == 0) ? {4'b0000, ld4} : ld8;
                    for (int i = 0; i < w; i++) begin
                        exp_q[d].push_back(word[(d == 1) ? (w - 1 - i) : i]);
                    end
                    acc[d] = 1'b1;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Producer: hold the word and valid until the model says it was taken.
    task automatic send(input int d, input logic [7:0] word);
        acc[d] = 1'b0;
        lv[d]  = 1'b1;
        if (d == 0) ld4 = word[3:0];
        else        ld8 = word;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (acc[d]) break;
        end
        check($sformatf("dut%0d word accepted", d), acc[d], 1);
        lv[d] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        lv  = '0;
        se  = '0;
        ld4 = '0;
        ld8 = '0;

        // Reset held with random traffic on the inputs.
        repeat (5) begin
            lv  = 2'($urandom);
            se  = 2'($urandom);
            ld4 = 4'($urandom);
            ld8 = 8'($urandom);
            cyc();
        end
        lv  = '0;
        se  = '0;
        rst = 1'b1;
        repeat (3) cyc();

        // Single word, LSB first.
        se = 2'b11;
        send(0, 8'b0000_1011);
        repeat (5) cyc();

        // Back-to-back words with load_valid held across the handover.
        send(0, 8'b0000_0110);
        send(0, 8'b0000_1001);
        repeat (5) cyc();

        // Stall while the third bit is on s_out.
        send(0, 8'b0000_1100);
        repeat (2) cyc();
        se[0] = 1'b0;
        repeat (3) begin
            cyc();
            check("stall s_out", so[0], 1);
            check("stall s_last", sl[0], 0);
            check("stall load_ready", lr[0], 0);
        end
        se[0] = 1'b1;
        repeat (5) cyc();

        // Asynchronous reset mid-frame, then a clean word.
        send(0, 8'b0000_1111);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("async reset s_out", so[0], 0);
        check("async reset s_valid", sv[0], 0);
        check("async reset s_last", sl[0], 0);
        check("async reset busy", bz[0], 0);
        check("async reset load_ready", lr[0], 1);
        repeat (2) cyc();
        rst = 1'b1;
        cyc();
        send(0, 8'b0000_0001);
        repeat (5) cyc();

        // MSB first, 8 bits.
        send(1, 8'hA5);
        repeat (10) cyc();

        // Random producers and random stalls on both instances.
        for (int c = 0; c < 600; c++) begin
            for (int d = 0; d < 2; d++) begin
                se[d] = ($urandom_range(0, 3) != 0);
                if (!lv[d] || acc[d]) begin
                    acc[d] = 1'b0;
                    lv[d]  = 1'($urandom_range(0, 1));
                    if (d == 0) ld4 = 4'($urandom);
                    else        ld8 = 8'($urandom);
                end
            end
            cyc();
        end
        lv = '0;
        se = 2'b11;
        repeat (12) cyc();
        check("dut0 drained", exp_q[0].size(), 0);
        check("dut1 drained", exp_q[1].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/piso_shift_register.md
Name: piso_shift_register

Overview:
- Parallel-in, serial-out shift register: the transmit-side counterpart of the team's serial-in, parallel-out right-shift register.
- Accepts a WIDTH-bit word through a valid/ready load handshake, then serialises it one bit per enabled clock.
- Supports back-to-back words with no idle gap, so a stream can feed a serial-in register bit-for-bit.

Parameters:
- WIDTH, 4, word width in bits; legal range WIDTH >= 2.
- MSB_FIRST, 0, bit order. 0 = LSB first, i.e. shift right. 1 = MSB first.

Ports:
- clk  input  1  system clock; rising edge active.
- rst  input  1  reset; asynchronous, active-low (0 = reset).
- load_valid  input  1  producer offers load_data this cycle.
- load_data  input  WIDTH  parallel word to serialise.
- load_ready  output  1  block accepts load_data on this edge if load_valid=1.
- shift_en  input  1  advance one bit on this edge. 0 = stall.
- s_out  output  1  current serial bit.
- s_valid  output  1  s_out carries a frame bit.
- s_last  output  1  s_out is the final bit of the current word.
- busy  output  1  a word is in progress (state SHIFT).

Behaviour:
- State machine: two states, ST_IDLE and ST_SHIFT.
  - Registers: shreg[WIDTH-1:0] and cnt[$clog2(WIDTH)-1:0].
- Reset (rst=0, asynchronous, any state):
  - state=ST_IDLE, shreg=0, cnt=0.
  - Outputs: s_out=0, s_valid=0, s_last=0, busy=0, load_ready=1.
  - A partial word is discarded, with no completion indication.
- load_ready (combinational):
  - 1 in ST_IDLE.
  - 1 in ST_SHIFT only when shift_en=1 and cnt==WIDTH-1.
  - 0 otherwise.
- Accept = load_valid & load_ready at a rising edge. On accept:
  - shreg<=load_data, cnt<=0, state<=ST_SHIFT.
- ST_IDLE:
  - s_out=0, s_valid=0, s_last=0, busy=0.
  - Without accept: remain in ST_IDLE. load_data is ignored.
- ST_SHIFT outputs:
  - s_valid=1, busy=1.
  - s_out = shreg[0] when MSB_FIRST=0, shreg[WIDTH-1] when MSB_FIRST=1.
  - s_last = (cnt==WIDTH-1).
- ST_SHIFT at an edge with shift_en=1 and cnt<WIDTH-1:
  - MSB_FIRST=0: logical shift right, zero fill at the MSB.
  - MSB_FIRST=1: shift left, zero fill at the LSB.
  - cnt<=cnt+1.
- ST_SHIFT at an edge with shift_en=1 and cnt==WIDTH-1:
  - If accept: reload as above, staying in ST_SHIFT (zero-gap back-to-back).
  - Else: state<=ST_IDLE, shreg<=0, cnt<=0.
- ST_SHIFT at an edge with shift_en=0: shreg, cnt and state hold, and all outputs hold.
- Latency:
  - Word accepted at edge k: bit 0 (per bit order) is visible on s_out after edge k.
  - Final bit is visible after the (WIDTH-1)th subsequent enabled edge.
  - Total WIDTH enabled cycles per word.
- load_valid while busy and not on the last bit: not accepted. The producer holds load_data and load_valid until load_ready.
- shift_en in ST_IDLE: no effect.
- cnt never exceeds WIDTH-1. No wrap-around beyond a word.
- All outputs are registered except load_ready, which is combinational from state, cnt and shift_en. There is no combinational path from load_valid.

Decomposition:
- shift_reg_pkg:
  - state localparams ST_IDLE=1'b0, ST_SHIFT=1'b1;
  - bit-order constants ORDER_LSB=0, ORDER_MSB=1;
  - a clog2 function for cnt width.
- One sub-module: mod_counter (parameter MOD).
  - Async active-low reset, synchronous clear, enable, terminal-count flag.
  - Used for cnt, with terminal count driving s_last and load_ready.

Test Plan:
1. Hold rst=0 for 5 cycles with random load_valid/load_data -> s_out=0, s_valid=0, s_last=0, busy=0, load_ready=1 throughout. Release: no load until load_valid.
2. WIDTH=4, MSB_FIRST=0, load 4'b1011, shift_en=1 -> s_out 1,1,0,1 on 4 consecutive cycles, s_last only on the 4th. Next cycle s_valid=0, busy=0.
3. Back-to-back: load 4'b0110, then present 4'b1001 with load_valid held -> accepted on the last-bit edge. s_out stream 0,1,1,0,1,0,0,1 with s_valid continuously 1, s_last on bits 4 and 8.
4. Stall: load 4'b1100, drop shift_en for 3 cycles after 2nd bit -> s_out holds 1, s_last=0, load_ready=0. Resume -> remaining bits 1,1.
5. Reset mid-frame: assert rst=0 mid-cycle after 2 bits of 4'b1111 -> outputs clear immediately without a clock. After release, load 4'b0001 -> 1,0,0,0 with no residue.
6. MSB_FIRST=1, WIDTH=8, load 8'hA5 -> s_out 1,0,1,0,0,1,0,1, s_last on 8th bit.
